harmonic_detector: RTL and testbench

Single-bin correlating detector, the receive side of the phasor synthesis path. It accepts one frame of 256 signed samples, one fundamental period at one ROM step per sample. It multiplies each sample by the sine and cosine of the selected harmonic, taken from the shared quarter-free 256-entry `sync_rom`, and accumulates both products. At frame end it presents the in-phase and quadrature sums, which the harmonic-analysis logic uses to recover the magnitude and phase that `phasor`-style generators injected.

---
 rtl/harmonic_detector.sv | 159 +++++++++++++++
 tb/tb_harmonic_detector.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/harmonic_detector.sv
// Single-bin correlating detector: multiplies one 256-sample frame by the sine and
// cosine of a selected harmonic and accumulates the in-phase and quadrature sums.

module sync_rom (
    input  logic               i_clk,
    input  logic [7:0]         i_addr,
    output logic signed [15:0] o_data
);
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned DATA_W = 16;

    // Full-period table, round(32767 * sin(2*pi*k/256)), built at elaboration.
    function automatic logic [DEPTH*DATA_W-1:0] build_sine();
        logic [DEPTH*DATA_W-1:0] table_bits;
        real v;
        int  q;
        table_bits = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            v = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
            q = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
            table_bits[k*DATA_W +: DATA_W] = 16'(q);
        end
        return table_bits;
    endfunction

    localparam logic [DEPTH*DATA_W-1:0] SINE_TABLE = build_sine();

    always_ff @(posedge i_clk) begin
        o_data <= SINE_TABLE[{i_addr, 4'd0} +: DATA_W];
    end
endmodule

module harmonic_detector #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned ACC_W     = 44
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0]              freq,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [19:0]      in_sample,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] sin_acc,
    output logic signed [ACC_W-1:0] cos_acc
);
    localparam int unsigned SAMPLE_W   = 20;
    localparam int unsigned COEF_W     = 16;
    localparam int unsigned PROD_W     = SAMPLE_W + COEF_W;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned CNT_W      = $clog2(FRAME_LEN);
    localparam int unsigned COS_OFFSET = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [3:0]                r_freq;
    logic [ADDR_W-1:0]         r_addr;
    logic [CNT_W-1:0]          r_count;
    logic                      w_start_ok;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_finish;
    logic [ADDR_W-1:0]         w_cos_addr;
    logic signed [COEF_W-1:0]  w_sin_coef;
    logic signed [COEF_W-1:0]  w_cos_coef;
    logic                      r_v0;
    logic                      r_v1;
    logic signed [SAMPLE_W-1:0] r_s0_sample;
    logic signed [PROD_W-1:0]  r_sin_prod;
    logic signed [PROD_W-1:0]  r_cos_prod;
    logic                      r_in_ready;
    logic                      r_busy;
    logic                      r_out_valid;
    logic signed [ACC_W-1:0]   r_sin_acc;
    logic signed [ACC_W-1:0]   r_cos_acc;

    assign w_start_ok = start && (freq != 4'd0) && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept   = r_in_ready && in_valid;
    assign w_last     = w_accept && (r_count == CNT_W'(FRAME_LEN - 1));
    assign w_finish   = (r_state == ST_DRAIN) && (w_next_state == ST_DONE);
    assign w_cos_addr = r_addr + ADDR_W'(COS_OFFSET);

    sync_rom u_sin_rom (.i_clk(clk), .i_addr(r_addr),     .o_data(w_sin_coef));
    sync_rom u_cos_rom (.i_clk(clk), .i_addr(w_cos_addr), .o_data(w_cos_coef));

    // DRAIN completes once neither pipeline stage holds a pending product.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_next_state = ST_ACQ;
            ST_ACQ:   if (w_last) w_next_state = ST_DRAIN;
            ST_DRAIN: if (!r_v0 && !r_v1) w_next_state = ST_DONE;
            ST_DONE:  if (w_start_ok) w_next_state = ST_ACQ;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_freq      <= 4'd0;
            r_addr      <= '0;
            r_count     <= '0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_sin_acc   <= '0;
            r_cos_acc   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == ST_ACQ);
            r_busy      <= (w_next_state == ST_ACQ) || (w_next_state == ST_DRAIN) || w_finish;
            r_out_valid <= w_finish;
            r_v0        <= w_accept;
            r_v1        <= r_v0;
            if (w_start_ok) begin
                r_freq  <= freq;
                r_addr  <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                r_addr  <= r_addr + ADDR_W'(r_freq);
                r_count <= r_count + CNT_W'(1);
            end
            if (w_start_ok) begin
                r_sin_acc <= '0;
                r_cos_acc <= '0;
            end else if (r_v1) begin
                r_sin_acc <= r_sin_acc + ACC_W'(r_sin_prod);
                r_cos_acc <= r_cos_acc + ACC_W'(r_cos_prod);
            end
        end
    end

    // Datapath registers; qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s0_sample <= in_sample;
        end
        if (r_v0) begin
            r_sin_prod <= PROD_W'(r_s0_sample) * PROD_W'(w_sin_coef);
            r_cos_prod <= PROD_W'(r_s0_sample) * PROD_W'(w_cos_coef);
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign sin_acc   = r_sin_acc;
    assign cos_acc   = r_cos_acc;
endmodule

// File: tb/tb_harmonic_detector.sv
// Bench for harmonic_detector: directed frames and random frames checked against a
// dot-product reference computed from the sine table formula.

module tb_harmonic_detector;
    localparam int ACC_W = 44;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [3:0]              freq;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [19:0]      in_sample;
    logic                    busy;
    logic                    out_valid;
    logic signed [ACC_W-1:0] sin_acc;
    logic signed [ACC_W-1:0] cos_acc;

    int     n_checks = 0;
    int     n_fails  = 0;
    int     x [256];
    longint golden;

    harmonic_detector #(.FRAME_LEN(256), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .freq(freq),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .busy(busy), .out_valid(out_valid), .sin_acc(sin_acc), .cos_acc(cos_acc)
    );

    always #5 clk = ~clk;

    function automatic int rom_val(int a);
        real v;
        v = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(a % 256) / 256.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic longint labs(longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference correlation: sum of x[n] times sine/cosine of phase n*f (mod 256).
    task automatic model(input int f, output longint s, output longint c);
        s = 0;
        c = 0;
        for (int n = 0; n < 256; n++) begin
            s += longint'(x[n]) * longint'(rom_val((n * f) % 256));
            c += longint'(x[n]) * longint'(rom_val((n * f + 64) % 256));
        end
    endtask

    task automatic run_frame(input string tag, input int f, input bit stall,
                             input int poke_at, input int abort_at, input bit chain);
        int     n;
        int     cyc;
        int     k;
        bit     acc;
        bit     poked;
        longint es;
        longint ec;
        n = 0;
        cyc = 0;
        poked = 0;
        start = 1'b1;
        freq  = 4'(f);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_on"}, longint'(busy), 1);
        check({tag, "_ready_on"}, longint'(in_ready), 1);
        check({tag, "_sin_clr"}, longint'(sin_acc), 0);
        check({tag, "_cos_clr"}, longint'(cos_acc), 0);
        while (n < 256 && cyc < 4000) begin
            if (n == abort_at) begin
                reset    = 1'b1;
                in_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                check({tag, "_rst_ready"}, longint'(in_ready), 0);
                check({tag, "_rst_busy"}, longint'(busy), 0);
                check({tag, "_rst_ovalid"}, longint'(out_valid), 0);
                check({tag, "_rst_sin"}, longint'(sin_acc), 0);
                check({tag, "_rst_cos"}, longint'(cos_acc), 0);
                return;
            end
            in_valid  = stall ? ($urandom_range(0, 99) < 43) : 1'b1;
            in_sample = 20'(x[n]);
            if (n == poke_at && !poked) begin
                start = 1'b1;
                freq  = 4'(f % 15 + 1);
                poked = 1;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) n++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_accepts"}, longint'(n), 256);
        check({tag, "_ready_off"}, longint'(in_ready), 0);
        k = 0;
        while (out_valid !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, longint'(k), 3);
        check({tag, "_busy_at_ovalid"}, longint'(busy), 1);
        model(f, es, ec);
        check({tag, "_sin"}, longint'(sin_acc), es);
        check({tag, "_cos"}, longint'(cos_acc), ec);
        if (!chain) begin
            @(posedge clk); #1;
            check({tag, "_ovalid_pulse"}, longint'(out_valid), 0);
            check({tag, "_busy_off"}, longint'(busy), 0);
            check({tag, "_sin_hold"}, longint'(sin_acc), es);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        freq      = 4'd0;
        in_valid  = 1'b0;
        in_sample = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", longint'(in_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_ovalid", longint'(out_valid), 0);
        check("rst_sin", longint'(sin_acc), 0);
        check("rst_cos", longint'(cos_acc), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // start with freq=0 must leave the block idle
        start = 1'b1;
        freq  = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("freq0_busy", longint'(busy), 0);
        check("freq0_ready", longint'(in_ready), 0);

        for (int n = 0; n < 256; n++) x[n] = 0;
        run_frame("zero", 1, 0, -1, -1, 0);

        golden = 0;
        for (int n = 0; n < 256; n++) begin
            x[n] = 3 * rom_val(n);
            golden += 3 * longint'(rom_val(n)) * longint'(rom_val(n));
        end
        run_frame("mag3", 1, 0, -1, -1, 0);
        check("mag3_golden", longint'(sin_acc), golden);
        check("mag3_cos_small", (labs(longint'(cos_acc)) < (64'sd1 <<< 24)) ? 1 : 0, 1);

        for (int n = 0; n < 256; n++) x[n] = -3 * rom_val(n);
        run_frame("magm3", 1, 0, -1, -1, 0);
        check("magm3_negated", longint'(sin_acc), -golden);

        for (int n = 0; n < 256; n++) x[n] = 7 * rom_val((2 * n) % 256);
        run_frame("orth", 1, 0, -1, -1, 0);
        check("orth_sin_small", (labs(longint'(sin_acc)) < (64'sd7 <<< 24)) ? 1 : 0, 1);
        check("orth_cos_small", (labs(longint'(cos_acc)) < (64'sd7 <<< 24)) ? 1 : 0, 1);

        for (int n = 0; n < 256; n++) x[n] = 3 * rom_val(n);
        run_frame("stall", 1, 1, -1, -1, 0);
        check("stall_golden", longint'(sin_acc), golden);

        for (int n = 0; n < 256; n++) x[n] = int'($urandom_range(0, 1048575)) - 524288;
        run_frame("rand_poke", int'($urandom_range(1, 15)), 1, 50, -1, 0);

        run_frame("abort", 5, 0, -1, 100, 0);

        for (int n = 0; n < 256; n++) x[n] = int'($urandom_range(0, 1048575)) - 524288;
        run_frame("after_abort", int'($urandom_range(1, 15)), 1, -1, -1, 1);
        for (int n = 0; n < 256; n++) x[n] = int'($urandom_range(0, 1048575)) - 524288;
        run_frame("b2b", 15, 0, -1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
